// File: rtl/wb_uart_rx_pkg.sv
// uart_pkg: register map, STATUS bit layout and receiver state encoding for wb_uart_rx.
package uart_pkg;
   localparam logic [31:0] UART_RX_DATA   = 32'h0;
   localparam logic [31:0] UART_RX_STATUS = 32'h4;
   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAME_ERR = 3;
   localparam int ST_LEVEL_LSB = 8;
   localparam int UART_DATA_BITS = 8;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} uart_rx_state_t;
endpackage

// File: rtl/wb_uart_rx_if.sv
// wb_uart_rx_if: Wishbone slave bus bundle, signal suffixes seen from the slave side.
interface wb_uart_rx_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0] wb_addr_i;
   logic [DW-1:0] wb_data_i;
   logic [3:0]    wb_sel_i;
   logic          wb_we_i;
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic          wb_ack_o;
   logic [DW-1:0] wb_data_o;
   modport master (output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, input wb_ack_o, wb_data_o);
   modport slave (input wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, output wb_ack_o, wb_data_o);
endinterface

// File: rtl/wb_uart_rx_fifo.sv
// sync_fifo: single-clock FIFO; a pop frees a full slot for a same-cycle push, a pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     drop_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] level_q;
   logic do_push, do_pop;
   assign empty_o = level_q == '0;
   assign full_o  = level_q == LW'(DEPTH);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign drop_o  = push_i && !do_push;
   assign data_o  = mem_q[rd_q];
   assign level_o = level_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         level_q <= level_q + LW'(do_push) - LW'(do_pop);
      end
   end
   always_ff @(posedge clk_i) if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/wb_uart_rx.sv
// wb_uart_rx: 8N1 UART receiver with RX FIFO behind a two-register Wishbone slave.
module wb_uart_rx
   import uart_pkg::*;
#(
   parameter int WB_DATA_WIDTH = 32,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int CLKS_PER_BIT  = 16,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          uart_rx_i,
   wb_uart_rx_if.slave   wb,
   output logic          rx_irq_o
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   uart_rx_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d, head;
   logic [WB_DATA_WIDTH-1:0] rdata_q, rd_data, status;
   logic [LW-1:0] level;
   logic s1_q, rx_s_q, push_q, push_d, frame_q, frame_set, ovr_q, ack_q, irq_q;
   logic tick, req, pop, wr_stat, fifo_full, fifo_empty, fifo_drop, unused_ok;
   assign tick = cnt_q == CW'(1);
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q - CW'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      push_d    = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         RX_IDLE: if (!rx_s_q) begin
            state_d = RX_START;
            cnt_d   = CW'(CLKS_PER_BIT / 2);
         end
         RX_START: if (tick) begin
            state_d = rx_s_q ? RX_IDLE : RX_DATA;
            cnt_d   = CW'(CLKS_PER_BIT);
            bit_d   = '0;
         end
         RX_DATA: if (tick) begin
            shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
            cnt_d   = CW'(CLKS_PER_BIT);
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'(UART_DATA_BITS - 1) ? RX_STOP : RX_DATA;
         end
         RX_STOP: if (tick) begin
            push_d    = rx_s_q;
            frame_set = !rx_s_q;
            state_d   = rx_s_q ? RX_IDLE : RX_BREAK;
         end
         RX_BREAK: if (rx_s_q) state_d = RX_IDLE;
         default: state_d = RX_IDLE;
      endcase
   end
   sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(push_q), .pop_i(pop), .data_i(shift_q),
      .data_o(head), .full_o(fifo_full), .empty_o(fifo_empty), .drop_o(fifo_drop), .level_o(level)
   );
   assign req     = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
   assign pop     = req && !wb.wb_we_i && wb.wb_addr_i[2] == UART_RX_DATA[2];
   assign wr_stat = req && wb.wb_we_i && wb.wb_addr_i[2] == UART_RX_STATUS[2];
   always_comb begin
      status                      = '0;
      status[ST_NOT_EMPTY]        = !fifo_empty;
      status[ST_FULL]             = fifo_full;
      status[ST_OVERRUN]          = ovr_q;
      status[ST_FRAME_ERR]        = frame_q;
      status[ST_LEVEL_LSB +: LW]  = level;
   end
   assign rd_data = wb.wb_we_i ? '0
                  : wb.wb_addr_i[2] == UART_RX_STATUS[2] ? status
                  : fifo_empty ? '0 : WB_DATA_WIDTH'({1'b1, head});
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q    <= 1'b1;
         rx_s_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         push_q  <= 1'b0;
         frame_q <= 1'b0;
         ovr_q   <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         s1_q    <= uart_rx_i;
         rx_s_q  <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         push_q  <= push_d;
         // a set event wins over a same-cycle W1C
         frame_q <= frame_set || (frame_q && !(wr_stat && wb.wb_data_i[ST_FRAME_ERR]));
         ovr_q   <= fifo_drop || (ovr_q && !(wr_stat && wb.wb_data_i[ST_OVERRUN]));
         ack_q   <= req;
         if (req) rdata_q <= rd_data;
         irq_q   <= !fifo_empty;
      end
   end
   assign wb.wb_ack_o  = ack_q;
   assign wb.wb_data_o = rdata_q;
   assign rx_irq_o     = irq_q;
   assign unused_ok = ^{wb.wb_sel_i, wb.wb_addr_i[WB_ADDR_WIDTH-1:3], wb.wb_addr_i[1:0],
                        wb.wb_data_i[WB_DATA_WIDTH-1:4], wb.wb_data_i[1:0]};
endmodule

// File: doc/wb_uart_rx.md
# wb_uart_rx

Wishbone-slave UART receiver that deserialises 8N1 frames from the SoC `uart_rx_i` pin, buffers received bytes in a FIFO and exposes them through a two-register bus interface. It sits beside the transmit-only UART on the `soc` bus mux as a separate slave. It is the upstream stage that feeds received characters to the CPU, by polling or via `rx_irq_o`.

## Interface
- `WB_DATA_WIDTH`, 32: bus data width; only 32 supported.
- `WB_ADDR_WIDTH`, 32: bus address width; only `wb_addr_i[2]` is decoded.
- `CLKS_PER_BIT`, 16: clock cycles per bit; must be ≥ 4, need not be even.
- `FIFO_DEPTH`, 16: RX FIFO entries; power of two, 2..256.
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `uart_rx_i`  in  1  asynchronous serial input; idle high.
- `wb_addr_i`  in  WB_ADDR_WIDTH  byte address.
- `wb_data_i`  in  32  write data.
- `wb_sel_i`  in  4  byte lanes; ignored, all accesses are treated as full-word.
- `wb_we_i`  in  1  write enable.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_ack_o`  out  1  single-cycle acknowledge; reset 0.
- `wb_data_o`  out  32  read data; reset 0.
- `rx_irq_o`  out  1  high while FIFO non-empty; reset 0.

## Operation
- Input path:
  - `uart_rx_i` passes through a 2-flop synchroniser reset to 1, giving `rx_s`.
  - Sampling uses `rx_s` only.
- Receiver FSM: IDLE → START → DATA → STOP → (IDLE | BREAK).
  - IDLE: on `rx_s`=0, load bit counter with `CLKS_PER_BIT/2` (floor) and enter START.
  - START: at counter expiry, sample `rx_s`. If 0, enter DATA with counter `CLKS_PER_BIT`. If 1, it is a false start: return to IDLE with nothing pushed.
  - DATA: 8 samples, each `CLKS_PER_BIT` cycles apart, shifted in LSB first. After the 8th, enter STOP.
  - STOP: one sample after `CLKS_PER_BIT`.
    - `rx_s`=1: push the byte and go to IDLE.
    - `rx_s`=0: set sticky `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents re-triggering on a held-low line.
- FIFO:
  - Level counter width is `$clog2(FIFO_DEPTH)+1`.
  - A push while full drops the new byte and sets sticky `overrun`; FIFO contents are unchanged.
  - A push and a pop in the same cycle while full are both accepted, with no overrun.
  - A push and a pop in the same cycle while empty: the pop is a no-op and the push is accepted.
- Registers, selected by `wb_addr_i[2]`:
  - 0 DATA, read: `{23'b0, valid, byte}`. `valid`=1 and the head byte are returned if non-empty, and the entry is popped. If empty, the read returns 0 and pops nothing. Writes are acked and ignored.
  - 1 STATUS, read: bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bits[16:8] level (zero-extended), all other bits 0.
  - 1 STATUS, write: W1C on bits 2 and 3. A clear in the same cycle as a new set event leaves the flag set.
- `rx_irq_o` = not_empty, registered from the FIFO level.
- Reset:
  - FSM returns to IDLE and the FIFO empties.
  - Sticky flags clear and the synchroniser is set to 1.
  - A frame in progress is discarded.

## Timing
- Ack:
  - `wb_ack_o` is asserted the cycle after `wb_cyc_i & wb_stb_i & !wb_ack_o`, for exactly one cycle.
  - `wb_data_o` is valid in the same cycle as the ack.
  - Back-to-back strobes are acked every other cycle.
- DATA pop takes effect at the clock edge that asserts `wb_ack_o`. The level is updated in the following cycle.
- Sample points: with the falling edge seen on `rx_s` at cycle T0:
  - start sample at T0+`CLKS_PER_BIT/2`;
  - data bit k at T0+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`;
  - stop bit at T0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- Push occurs in the cycle after the stop sample. `rx_irq_o` rises one cycle after the push.
- Pin-to-`rx_s` latency is 2 cycles.

## Structure
- Package `uart_pkg`:
  - register offsets `UART_RX_DATA`=0x0 and `UART_RX_STATUS`=0x4;
  - STATUS bit positions;
  - `UART_DATA_BITS`=8;
  - FSM state enum `uart_rx_state_t`.
- Sub-module `sync_fifo`, parameterised by width and depth. It provides push, pop, full, empty and level, with the simultaneous push/pop rules above implemented inside it.
- The top level holds the synchroniser, FSM, bit counter, shift register and Wishbone decode.

## Test plan
All cases use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=16.
- Single byte: send frame 0xA5 → `rx_irq_o`=1; STATUS = 0x101; DATA read = 0x1A5; then STATUS = 0x0 and `rx_irq_o`=0.
- Glitch: hold line low for 5 cycles, then high → FSM back in IDLE; STATUS = 0x0; nothing pushed.
- Frame error: send 0x3C with stop bit 0, held low for 40 cycles → STATUS bit3=1 and level 0. No new frame is detected until the line goes high. Write 0x8 to STATUS → 0x0.
- Overrun:
  - Send 17 bytes 0x00..0x10 without reading → STATUS = 0x1007 (level 16, full, overrun, not_empty).
  - 16 DATA reads return 0x100..0x10F in order; a 17th read returns 0x0.
- Simultaneous: with the FIFO full, align a DATA read ack with the push cycle of byte 0x55 → no overrun, level stays 16, and 0x55 is the last entry read.
- Reset mid-frame: assert `rst_i` for 1 cycle during data bit 4 → STATUS = 0x0 and outputs at reset values. A following clean frame 0x81 is received correctly.
